// File: rtl/div_ratio_pkg.sv
// Shared types and defaults for the divide-ratio control stage.
package div_ratio_pkg;
  localparam int NW_DEF        = 3;
  localparam int DEFAULT_N_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_e;
endpackage

// File: rtl/div_ratio_fifo.sv
// Synchronous request FIFO (DEPTH x NW); pointers wrap modulo DEPTH, level counts 0..DEPTH.
module div_ratio_fifo #(
  parameter  int DEPTH = 4,
  parameter  int NW    = 3,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [NW-1:0] din,
  output logic [NW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [NW-1:0] mem_q [DEPTH];
  logic [NW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // A push on a full FIFO is refused even when a pop frees a slot this cycle.
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    level_d = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/div_ratio_ctrl.sv
// Divide-ratio control: queues ratios and applies them on period boundaries after a hold.
// Optional macro DIV_RATIO_SKIP_SAME_EN: entries equal to the current ratio are dropped silently.
module div_ratio_ctrl
  import div_ratio_pkg::*;
#(
  parameter  int NW        = NW_DEF,
  parameter  int DEPTH     = 4,
  parameter  int HOLD_MIN  = 2,
  parameter  int DEFAULT_N = DEFAULT_N_DEF,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic          ref_clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [NW-1:0] req_n,
  input  logic          period_tick,
  output logic [NW-1:0] n,
  output logic          n_update,
  output logic          busy,
  output logic          err_zero,
  output logic [LW-1:0] fifo_level
);
  localparam logic [NW-1:0] HOLD_SAT  = NW'(HOLD_MIN);
  localparam logic [NW-1:0] HOLD_LAST = NW'(HOLD_MIN - 1);

  state_e        state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [NW-1:0] hold_cnt_q, hold_cnt_d;
  logic          n_update_q, n_update_d;
  logic          err_zero_q, err_zero_d;

  logic          fifo_full, fifo_empty, fifo_pop;
  logic [NW-1:0] fifo_head;
  logic          accept, push, skip_same;

  assign req_ready = ~fifo_full;
  assign accept    = req_valid & req_ready;
  assign push      = accept & (req_n != '0);

  div_ratio_fifo #(.DEPTH(DEPTH), .NW(NW)) u_fifo (
    .clk   (ref_clk),
    .reset (reset),
    .push  (push),
    .pop   (fifo_pop),
    .din   (req_n),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef DIV_RATIO_SKIP_SAME_EN
  assign skip_same = (fifo_head == n_q);
`else
  assign skip_same = 1'b0;
`endif

  // Next state looks at the FIFO as it will be after this edge, so state IDLE
  // always means "empty and hold satisfied" and a fresh push is armed at once.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    hold_cnt_d = hold_cnt_q;
    n_update_d = 1'b0;
    fifo_pop   = 1'b0;
    err_zero_d = err_zero_q | (accept & (req_n == '0));
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty || push) state_d = ARMED;
      end
      ARMED: begin
        if (period_tick && !fifo_empty) begin
          fifo_pop = 1'b1;
          if (!skip_same) begin
            n_d        = fifo_head;
            n_update_d = 1'b1;
            hold_cnt_d = '0;
          end
          if (!skip_same && HOLD_MIN > 0) state_d = HOLD;
          else if (fifo_level > LW'(1) || push) state_d = ARMED;
          else state_d = IDLE;
        end else if (fifo_empty && !push) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (period_tick) begin
          if (hold_cnt_q != HOLD_SAT) hold_cnt_d = hold_cnt_q + NW'(1);
          // The completing tick only releases the hold; switching waits for the next one.
          if (hold_cnt_q == HOLD_LAST || hold_cnt_q == HOLD_SAT)
            state_d = (!fifo_empty || push) ? ARMED : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      n_q        <= NW'(DEFAULT_N);
      hold_cnt_q <= HOLD_SAT;
      n_update_q <= 1'b0;
      err_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      hold_cnt_q <= hold_cnt_d;
      n_update_q <= n_update_d;
      err_zero_q <= err_zero_d;
    end
  end

  assign n        = n_q;
  assign n_update = n_update_q;
  assign err_zero = err_zero_q;
  assign busy     = ~fifo_empty | (state_q != IDLE);
endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Self-checking bench for div_ratio_ctrl: directed scenarios plus random traffic vs a queue model.
module tb_div_ratio_ctrl;
  localparam int NW        = 3;
  localparam int DEPTH     = 4;
  localparam int HOLD_MIN  = 2;
  localparam int DEFAULT_N = 1;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic          ref_clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [NW-1:0] req_n = '0;
  logic          period_tick = 1'b0;
  logic [NW-1:0] n;
  logic          n_update;
  logic          busy;
  logic          err_zero;
  logic [LW-1:0] fifo_level;

  div_ratio_ctrl #(.NW(NW), .DEPTH(DEPTH), .HOLD_MIN(HOLD_MIN), .DEFAULT_N(DEFAULT_N)) dut (
    .ref_clk(ref_clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_n(req_n), .period_tick(period_tick), .n(n), .n_update(n_update),
    .busy(busy), .err_zero(err_zero), .fifo_level(fifo_level)
  );

  always #5 ref_clk = ~ref_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of pending ratios, current ratio, periods held so far.
  logic [NW-1:0] mq[$];
  logic [NW-1:0] m_n;
  int            m_hold;
  bit            m_upd, m_err;

  task automatic step(input bit v, input int rn, input bit tk, input bit rst = 1'b0);
    bit acc, sw;
    logic [NW-1:0] head, rv;
    rv = NW'(rn);
    reset = rst; req_valid = v; req_n = rv; period_tick = tk;
    @(posedge ref_clk);
    if (rst) begin
      mq.delete(); m_n = NW'(DEFAULT_N); m_hold = HOLD_MIN; m_upd = 0; m_err = 0;
    end else begin
      acc   = v && (mq.size() < DEPTH);
      sw    = tk && (m_hold == HOLD_MIN) && (mq.size() > 0);
      m_upd = 0;
      if (sw) begin
        head = mq.pop_front();
`ifdef DIV_RATIO_SKIP_SAME_EN
        if (head != m_n) begin m_n = head; m_upd = 1; m_hold = 0; end
`else
        m_n = head; m_upd = 1; m_hold = 0;
`endif
      end else if (tk && m_hold < HOLD_MIN) begin
        m_hold++;
      end
      if (acc) begin
        if (rv == '0) m_err = 1;
        else mq.push_back(rv);
      end
    end
    #1;
    reset = 1'b0; req_valid = 1'b0; period_tick = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step(0, 0, 0, 1);
    checks++; if (n !== NW'(DEFAULT_N)) begin errors++; $display("FAIL reset_n got=%0d exp=%0d", n, DEFAULT_N); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (err_zero !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_zero); end
  endtask

  task automatic test_basic();
    step(1, 5, 0);
    repeat (3) step(0, 0, 0);
    step(0, 0, 1);
    checks++; if (n !== 3'd5 || n_update !== 1'b1) begin errors++; $display("FAIL basic_switch got n=%0d upd=%b exp n=5 upd=1", n, n_update); end
    step(0, 0, 0);
    checks++; if (n_update !== 1'b0) begin errors++; $display("FAIL basic_upd_pulse got=%b exp=0", n_update); end
    step(1, 3, 0);
    step(0, 0, 0);
    for (int t = 1; t <= 2; t++) begin
      step(0, 0, 1);
      checks++; if (n !== 3'd5) begin errors++; $display("FAIL basic_hold_tick%0d got=%0d exp=5", t, n); end
      step(0, 0, 0);
    end
    step(0, 0, 1);
    checks++; if (n !== 3'd3 || n_update !== 1'b1) begin errors++; $display("FAIL basic_after_hold got n=%0d upd=%b exp n=3 upd=1", n, n_update); end
  endtask

  task automatic test_full();
    logic [NW-1:0] got[$];
    logic [NW-1:0] exp_order[4];
    exp_order = '{3'd2, 3'd3, 3'd4, 3'd7};
    step(0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) step(1, i, 0);
    checks++; if (fifo_level !== LW'(4) || req_ready !== 1'b0) begin errors++; $display("FAIL full_level got lvl=%0d rdy=%b exp lvl=4 rdy=0", fifo_level, req_ready); end
    repeat (2) step(1, 7, 0);
    checks++; if (fifo_level !== LW'(4)) begin errors++; $display("FAIL full_no_push got=%0d exp=4", fifo_level); end
    step(1, 7, 1);
    checks++; if (n !== 3'd1 || fifo_level !== LW'(3) || req_ready !== 1'b1) begin errors++; $display("FAIL full_pop got n=%0d lvl=%0d rdy=%b exp n=1 lvl=3 rdy=1", n, fifo_level, req_ready); end
    step(1, 7, 0);
    checks++; if (fifo_level !== LW'(4)) begin errors++; $display("FAIL full_refill got=%0d exp=4", fifo_level); end
    for (int i = 0; i < 14; i++) begin
      step(0, 0, 1);
      if (n_update === 1'b1) got.push_back(n);
    end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL full_drain_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_order[i]) begin errors++; $display("FAIL full_order[%0d] got=%0d exp=%0d", i, got[i], exp_order[i]); end
    end
  endtask

  task automatic test_zero_simul();
    step(0, 0, 0, 1);
    step(1, 0, 0);
    checks++; if (err_zero !== 1'b1 || fifo_level !== '0 || req_ready !== 1'b1) begin errors++; $display("FAIL zero_drop got err=%b lvl=%0d rdy=%b exp err=1 lvl=0 rdy=1", err_zero, fifo_level, req_ready); end
    step(1, 6, 1);
    checks++; if (n !== 3'd1 || n_update !== 1'b0) begin errors++; $display("FAIL simul_no_switch got n=%0d upd=%b exp n=1 upd=0", n, n_update); end
    step(0, 0, 1);
    checks++; if (n !== 3'd6 || n_update !== 1'b1) begin errors++; $display("FAIL simul_next_tick got n=%0d upd=%b exp n=6 upd=1", n, n_update); end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 0, 1);
    step(1, 0, 0);
    step(1, 2, 0); step(1, 3, 0); step(1, 4, 0);
    step(0, 0, 1);
    step(1, 5, 0);
    checks++; if (n !== 3'd2 || fifo_level !== LW'(3) || busy !== 1'b1) begin errors++; $display("FAIL mid_setup got n=%0d lvl=%0d busy=%b exp n=2 lvl=3 busy=1", n, fifo_level, busy); end
    step(0, 0, 0, 1);
    checks++; if (n !== 3'd1 || fifo_level !== '0 || err_zero !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset got n=%0d lvl=%0d err=%b busy=%b exp n=1 lvl=0 err=0 busy=0", n, fifo_level, err_zero, busy); end
    step(1, 6, 0);
    step(0, 0, 1);
    checks++; if (n !== 3'd6 || n_update !== 1'b1) begin errors++; $display("FAIL mid_no_wait got n=%0d upd=%b exp n=6 upd=1", n, n_update); end
  endtask

  task automatic test_same_ratio();
    step(0, 0, 0, 1);
    step(1, 5, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    step(1, 5, 0);
    step(0, 0, 1);
`ifdef DIV_RATIO_SKIP_SAME_EN
    checks++; if (n_update !== 1'b0 || fifo_level !== '0 || busy !== 1'b0) begin errors++; $display("FAIL same_skip got upd=%b lvl=%0d busy=%b exp upd=0 lvl=0 busy=0", n_update, fifo_level, busy); end
`else
    checks++; if (n_update !== 1'b1 || fifo_level !== '0 || busy !== 1'b1) begin errors++; $display("FAIL same_apply got upd=%b lvl=%0d busy=%b exp upd=1 lvl=0 busy=1", n_update, fifo_level, busy); end
`endif
    checks++; if (n !== 3'd5) begin errors++; $display("FAIL same_n got=%0d exp=5", n); end
  endtask

  task automatic test_random();
    bit m_busy;
    step(0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 7),
           ($urandom_range(0, 99) < 30));
      m_busy = (mq.size() > 0) || (m_hold < HOLD_MIN);
      checks++;
      if (n !== m_n || n_update !== m_upd || fifo_level !== LW'(mq.size()) ||
          req_ready !== (mq.size() < DEPTH) || busy !== m_busy || err_zero !== m_err) begin
        errors++;
        $display("FAIL rand[%0d] got n=%0d upd=%b lvl=%0d rdy=%b busy=%b err=%b exp n=%0d upd=%b lvl=%0d rdy=%b busy=%b err=%b",
                 i, n, n_update, fifo_level, req_ready, busy, err_zero,
                 m_n, m_upd, mq.size(), (mq.size() < DEPTH), m_busy, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_zero_simul();
    test_reset_mid();
    test_same_ratio();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
